// File: rtl/pxs_split_n.sv
// Frame-aligned video stream splitter: fans one pixel stream out to N_OUT copies,
// each gated per output by an enable mask that only changes on frame starts.
module pxs_split_n #(
  parameter int N_OUT  = 2,
  parameter int PX_W   = 3,
  parameter bit VS_POL = 1'b0
) (
  input  logic                        px_clk,
  input  logic                        rst_n,
  input  logic [PX_W+22:0]            RGBStr_i,
  input  logic [N_OUT-1:0]            en_i,
  output logic [N_OUT*(PX_W+23)-1:0]  RGBStr_o,
  output logic [N_OUT-1:0]            mask_o,
  output logic                        locked_o,
  output logic [7:0]                  frame_cnt_o
);

  localparam int SW = PX_W + 23;

  typedef enum logic {
    SYNC_WAIT = 1'b0,
    RUN       = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [N_OUT-1:0]       mask_q, mask_d;
  logic [N_OUT-1:0]       m_eff;
  logic                   vs_prev_q;
  logic                   fs;
  logic [7:0]             cnt_q, cnt_d;
  logic [N_OUT*SW-1:0]    str_q, str_d;
  logic [SW-1:0]          blank;

  // A blanked stream keeps sync and coordinates so downstream timing is intact.
  assign blank = {{PX_W{1'b0}}, RGBStr_i[22:1], 1'b0};
  assign fs    = (RGBStr_i[1] == VS_POL) && (vs_prev_q != VS_POL);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    m_eff   = '0;
    cnt_d   = cnt_q;
    str_d   = '0;
    if (fs) begin
      state_d = RUN;
      mask_d  = en_i;
      m_eff   = en_i;
      cnt_d   = cnt_q + 8'd1;
    end else if (state_q == RUN) begin
      m_eff = mask_q;
    end
    for (int k = 0; k < N_OUT; k++) begin
      str_d[k*SW +: SW] = m_eff[k] ? RGBStr_i : blank;
    end
  end

  // vs_prev resets to the active level so a VS already active at release is not a frame start.
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SYNC_WAIT;
      mask_q    <= '0;
      vs_prev_q <= VS_POL;
      cnt_q     <= '0;
      str_q     <= '0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      vs_prev_q <= RGBStr_i[1];
      cnt_q     <= cnt_d;
      str_q     <= str_d;
    end
  end

  assign RGBStr_o    = str_q;
  assign mask_o      = mask_q;
  assign locked_o    = (state_q == RUN);
  assign frame_cnt_o = cnt_q;

endmodule

// File: doc/pxs_split_n.md
PXS_SPLIT_N -- requirements
Module: pxs_split_n

Interface
REQ-001 Parameter N_OUT, default 2, number of output streams (legal 2..8).
REQ-002 Parameter PX_W, default 3, pixel field width; stream width SW = PX_W+23.
REQ-003 Parameter VS_POL, default 0, active level of VSync (0 = active-low).
REQ-004 Stream layout SHALL be: bit0 Active, bit1 VS, bit2 HS, bits 12:3 YCoord, bits 22:13 XCoord, bits SW-1:23 pixel.
REQ-005 px_clk  in  1  pixel clock; all logic on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 RGBStr_i  in  SW  input video stream.
REQ-008 en_i  in  N_OUT  requested per-output enable mask; bit k controls output k.
REQ-009 RGBStr_o  out  N_OUT*SW  output streams; stream k occupies bits k*SW+SW-1 : k*SW.
REQ-010 mask_o  out  N_OUT  enable mask currently applied.
REQ-011 locked_o  out  1  high once the block is frame-aligned.
REQ-012 frame_cnt_o  out  8  count of frame starts seen while locked.

Function
REQ-013 Frame start (FS) SHALL be detected when input VS == VS_POL and vs_prev != VS_POL; vs_prev is the registered input VS.
REQ-014 State machine SHALL have two states: SYNC_WAIT (after reset) and RUN.
REQ-015 SYNC_WAIT -> RUN on the first FS; RUN has no exit except reset.
REQ-016 Effective mask m_eff SHALL be en_i on an FS cycle, mask register otherwise; in SYNC_WAIT without FS, m_eff = 0.
REQ-017 On every FS cycle the mask register SHALL load en_i; en_i changes between FS cycles SHALL NOT affect outputs (no partial frames).
REQ-018 Latency SHALL be exactly 1 cycle: stream k at cycle t+1 is derived from RGBStr_i at cycle t and m_eff at cycle t.
REQ-019 If m_eff[k] = 1, stream k SHALL be a bit-exact copy of RGBStr_i.
REQ-020 If m_eff[k] = 0, stream k SHALL carry input HS, VS, XCoord and YCoord unchanged, with Active = 0 and pixel = 0 (sync timing preserved downstream).
REQ-021 mask_o SHALL equal the mask register; locked_o SHALL be 1 exactly when state is RUN, updated in the same cycle as the first gated output.
REQ-022 frame_cnt_o SHALL increment by 1 on each FS (including the FS causing the transition to RUN) and wrap 255 -> 0.
REQ-023 An FS on the same cycle as an en_i change SHALL use the new en_i value for that beat.
REQ-024 All outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-025 While rst_n = 0, all bits of RGBStr_o, mask_o, locked_o and frame_cnt_o SHALL be 0 immediately, independent of px_clk.
REQ-026 Reset SHALL set state to SYNC_WAIT, mask register to 0, and vs_prev to VS_POL, so a VS already active at reset release is not an FS.
REQ-027 Reset asserted mid-frame SHALL discard the current frame; after release, outputs stay blanked until the next FS.

Verification
REQ-028 Reset release with VS held active, then 100 cycles of active video, en_i = 2'b11 -> all outputs Active = 0 and pixel = 0, locked_o = 0, frame_cnt_o = 0.
REQ-029 First VS edge into active with en_i = 2'b11 -> next cycle locked_o = 1, mask_o = 2'b11, frame_cnt_o = 1; both streams equal RGBStr_i delayed 1 cycle.
REQ-030 en_i changes 2'b11 -> 2'b01 mid-frame -> stream 1 stays an exact copy until the next FS; from the FS beat onward, stream 1 has Active = 0 and pixel = 0 with HS, VS and coordinates still matching the input.
REQ-031 en_i changes on the exact FS cycle -> the FS beat output already reflects the new mask.
REQ-032 257 frames in RUN -> frame_cnt_o wraps to 1 (1..255, 0, 1).
REQ-033 rst_n pulsed low mid-line -> outputs 0 asynchronously; after release, locked_o = 0 until the next FS.
REQ-034 N_OUT = 4, PX_W = 8 build, en_i = 4'b1010 -> streams 1 and 3 are copies, streams 0 and 2 are blanked; bus width 124.
